// File: rtl/id_ex_operand_stage_if.sv
// -----------------------------------------------------------------------------
// id_ex_operand_stage_if
// Bundle of all signals between decode, the ID/EX operand stage, the execute
// ALU and the two forwarding sources (EX/MEM and MEM/WB).
//
// Parameters:
//   DATA_WIDTH     operand/result width
//   REG_ADDR_WIDTH register-file index width
//
// Modports:
//   master : surrounding pipeline (decode, forward sources, execute)
//   slave  : the ID/EX operand stage itself
// -----------------------------------------------------------------------------
interface id_ex_operand_stage_if #(
   parameter int DATA_WIDTH     = 32,
   parameter int REG_ADDR_WIDTH = 5
);
   // decode side
   logic                      in_valid;
   logic                      in_ready;
   logic [DATA_WIDTH-1:0]     in_rs1_data;
   logic [DATA_WIDTH-1:0]     in_rs2_data;
   logic [REG_ADDR_WIDTH-1:0] in_rs1_addr;
   logic [REG_ADDR_WIDTH-1:0] in_rs2_addr;
   logic [REG_ADDR_WIDTH-1:0] in_rd_addr;
   logic                      in_reg_write;
   logic                      in_use_imm;
   logic [DATA_WIDTH-1:0]     in_imm;
   logic [3:0]                in_alu_control;
   logic                      flush;

   // forward sources
   logic                      exmem_reg_write;
   logic [REG_ADDR_WIDTH-1:0] exmem_rd_addr;
   logic [DATA_WIDTH-1:0]     exmem_result;
   logic                      memwb_reg_write;
   logic [REG_ADDR_WIDTH-1:0] memwb_rd_addr;
   logic [DATA_WIDTH-1:0]     memwb_result;

   // execute side
   logic                      out_valid;
   logic                      out_ready;
   logic [DATA_WIDTH-1:0]     out_rs1;
   logic [DATA_WIDTH-1:0]     out_rs2;
   logic [3:0]                out_alu_control;
   logic [REG_ADDR_WIDTH-1:0] out_rd_addr;
   logic                      out_reg_write;
   logic                      out_illegal;

   modport master (
      output in_valid, in_rs1_data, in_rs2_data, in_rs1_addr, in_rs2_addr,
             in_rd_addr, in_reg_write, in_use_imm, in_imm, in_alu_control, flush,
             exmem_reg_write, exmem_rd_addr, exmem_result,
             memwb_reg_write, memwb_rd_addr, memwb_result,
             out_ready,
      input  in_ready, out_valid, out_rs1, out_rs2, out_alu_control,
             out_rd_addr, out_reg_write, out_illegal
   );

   modport slave (
      input  in_valid, in_rs1_data, in_rs2_data, in_rs1_addr, in_rs2_addr,
             in_rd_addr, in_reg_write, in_use_imm, in_imm, in_alu_control, flush,
             exmem_reg_write, exmem_rd_addr, exmem_result,
             memwb_reg_write, memwb_rd_addr, memwb_result,
             out_ready,
      output in_ready, out_valid, out_rs1, out_rs2, out_alu_control,
             out_rd_addr, out_reg_write, out_illegal
   );
endinterface

// File: rtl/id_ex_operand_stage.sv
// -----------------------------------------------------------------------------
// id_ex_operand_stage
// ID/EX pipeline register in front of the execute ALU. Captures decoded
// operands, destination and ALU opcode, resolves RAW hazards by forwarding
// from EX/MEM (priority) and MEM/WB, and presents the operands to the ALU
// through a valid/ready handshake. While the ALU stalls, held register
// operands keep tracking the forward sources so a producer that retires
// during the stall is not lost. Opcodes 4'hc..4'hf are replaced by 4'ha with
// the write-back suppressed and out_illegal raised.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    id_ex_operand_stage_if.slave (decode, forward sources, execute)
//   fwd_exmem_count / fwd_memwb_count (only with ID_EX_FWD_COUNT_EN)
//          saturating 16-bit counts of capture/refresh cycles in which the
//          respective forward path supplied at least one operand
//
// Optional feature macro: ID_EX_FWD_COUNT_EN
// -----------------------------------------------------------------------------
module id_ex_operand_stage #(
   parameter int DATA_WIDTH     = 32,
   parameter int REG_ADDR_WIDTH = 5
) (
   input  logic                         clk,
   input  logic                         rst_n,
   id_ex_operand_stage_if.slave         bus
`ifdef ID_EX_FWD_COUNT_EN
   ,
   output logic [15:0]                  fwd_exmem_count,
   output logic [15:0]                  fwd_memwb_count
`endif
);

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_t;

   localparam logic [3:0] ALU_NOP = 4'ha;

   state_t                    r_state;
   state_t                    w_state_nxt;

   logic [DATA_WIDTH-1:0]     r_rs1;
   logic [DATA_WIDTH-1:0]     r_rs2;
   logic [3:0]                r_alu_control;
   logic [REG_ADDR_WIDTH-1:0] r_rd_addr;
   logic                      r_reg_write;
   logic                      r_illegal;
   logic [REG_ADDR_WIDTH-1:0] r_rs1_addr;
   logic [REG_ADDR_WIDTH-1:0] r_rs2_addr;
   logic                      r_use_imm;

   logic                      w_in_ready;
   logic                      w_load;
   logic                      w_hold;
   logic                      w_update;
   logic [REG_ADDR_WIDTH-1:0] w_rs1_addr;
   logic [REG_ADDR_WIDTH-1:0] w_rs2_addr;
   logic                      w_use_imm;
   logic [DATA_WIDTH-1:0]     w_rs1_base;
   logic [DATA_WIDTH-1:0]     w_rs2_base;
   logic                      w_rs1_ex;
   logic                      w_rs1_wb;
   logic                      w_rs2_ex;
   logic                      w_rs2_wb;
   logic [DATA_WIDTH-1:0]     w_rs1_val;
   logic [DATA_WIDTH-1:0]     w_rs2_val;
   logic                      w_legal;

   // A forward source matches only a real write to a non-zero register.
   function automatic logic f_hit(input logic                      we,
                                  input logic [REG_ADDR_WIDTH-1:0] rd,
                                  input logic [REG_ADDR_WIDTH-1:0] src);
      return we && (rd == src) && (src != '0);
   endfunction

   always_comb begin
      w_in_ready = (r_state == ST_EMPTY) || bus.out_ready;
      // flush wins over a simultaneous load regardless of in_ready
      w_load     = bus.in_valid && w_in_ready && !bus.flush;
      w_hold     = (r_state == ST_FULL) && !bus.out_ready && !bus.flush;
      w_update   = w_load || w_hold;

      // Same forwarding network serves capture (new addresses) and hold
      // refresh (stored addresses); on refresh a miss keeps the held value.
      w_rs1_addr = w_load ? bus.in_rs1_addr : r_rs1_addr;
      w_rs2_addr = w_load ? bus.in_rs2_addr : r_rs2_addr;
      w_use_imm  = w_load ? bus.in_use_imm  : r_use_imm;
      w_rs1_base = w_load ? bus.in_rs1_data : r_rs1;
      w_rs2_base = w_load ? (bus.in_use_imm ? bus.in_imm : bus.in_rs2_data) : r_rs2;

      w_rs1_ex   = f_hit(bus.exmem_reg_write, bus.exmem_rd_addr, w_rs1_addr);
      w_rs1_wb   = f_hit(bus.memwb_reg_write, bus.memwb_rd_addr, w_rs1_addr) && !w_rs1_ex;
      w_rs2_ex   = f_hit(bus.exmem_reg_write, bus.exmem_rd_addr, w_rs2_addr) && !w_use_imm;
      w_rs2_wb   = f_hit(bus.memwb_reg_write, bus.memwb_rd_addr, w_rs2_addr) && !w_use_imm
                   && !w_rs2_ex;

      w_rs1_val  = w_rs1_ex ? bus.exmem_result : (w_rs1_wb ? bus.memwb_result : w_rs1_base);
      w_rs2_val  = w_rs2_ex ? bus.exmem_result : (w_rs2_wb ? bus.memwb_result : w_rs2_base);

      w_legal    = (bus.in_alu_control <= 4'hb);
   end

   // FSM next state
   always_comb begin
      w_state_nxt = r_state;
      if (bus.flush) begin
         w_state_nxt = ST_EMPTY;
      end else begin
         case (r_state)
            ST_EMPTY: if (w_load) w_state_nxt = ST_FULL;
            ST_FULL:  if (bus.out_ready) w_state_nxt = w_load ? ST_FULL : ST_EMPTY;
            default:  w_state_nxt = ST_EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= ST_EMPTY;
      else        r_state <= w_state_nxt;
   end

   // ID/EX register boundary
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_rs1         <= '0;
         r_rs2         <= '0;
         r_alu_control <= ALU_NOP;
         r_rd_addr     <= '0;
         r_reg_write   <= 1'b0;
         r_illegal     <= 1'b0;
         r_rs1_addr    <= '0;
         r_rs2_addr    <= '0;
         r_use_imm     <= 1'b0;
      end else begin
         if (w_update) begin
            r_rs1 <= w_rs1_val;
            r_rs2 <= w_rs2_val;
         end
         if (w_load) begin
            r_rs1_addr    <= bus.in_rs1_addr;
            r_rs2_addr    <= bus.in_rs2_addr;
            r_use_imm     <= bus.in_use_imm;
            r_rd_addr     <= bus.in_rd_addr;
            r_alu_control <= w_legal ? bus.in_alu_control : ALU_NOP;
            r_reg_write   <= w_legal && bus.in_reg_write;
            r_illegal     <= !w_legal;
         end else if (bus.flush) begin
            r_reg_write   <= 1'b0;
         end
      end
   end

`ifdef ID_EX_FWD_COUNT_EN
   logic [15:0] r_fwd_exmem_cnt;
   logic [15:0] r_fwd_memwb_cnt;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_fwd_exmem_cnt <= '0;
         r_fwd_memwb_cnt <= '0;
      end else if (w_update) begin
         if ((w_rs1_ex || w_rs2_ex) && (r_fwd_exmem_cnt != 16'hffff))
            r_fwd_exmem_cnt <= r_fwd_exmem_cnt + 16'd1;
         if ((w_rs1_wb || w_rs2_wb) && (r_fwd_memwb_cnt != 16'hffff))
            r_fwd_memwb_cnt <= r_fwd_memwb_cnt + 16'd1;
      end
   end

   assign fwd_exmem_count = r_fwd_exmem_cnt;
   assign fwd_memwb_count = r_fwd_memwb_cnt;
`endif

   assign bus.in_ready        = w_in_ready;
   assign bus.out_valid       = (r_state == ST_FULL);
   assign bus.out_rs1         = r_rs1;
   assign bus.out_rs2         = r_rs2;
   assign bus.out_alu_control = r_alu_control;
   assign bus.out_rd_addr     = r_rd_addr;
   assign bus.out_reg_write   = r_reg_write;
   assign bus.out_illegal     = r_illegal;

endmodule

// File: doc/id_ex_operand_stage.md
Name: id_ex_operand_stage

Overview:
- ID/EX pipeline stage directly upstream of the execute ALU.
- Captures decoded operands, destination and 4-bit ALU opcode; resolves RAW hazards by forwarding from EX/MEM and MEM/WB.
- Presents registered rs1/rs2/aluControl to the ALU via a valid/ready handshake, with stall hold and flush.

Parameters:
- DATA_WIDTH, 32, operand/result width.
- REG_ADDR_WIDTH, 5, register-file index width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous reset, active-low.
- in_valid  in  1  decode holds a valid instruction.
- in_ready  out  1  stage can accept this cycle.
- in_rs1_data / in_rs2_data  in  DATA_WIDTH  register-file read data.
- in_rs1_addr / in_rs2_addr  in  REG_ADDR_WIDTH  source indices.
- in_rd_addr  in  REG_ADDR_WIDTH  destination index.
- in_reg_write  in  1  instruction writes rd.
- in_use_imm  in  1  operand 2 is immediate.
- in_imm  in  DATA_WIDTH  sign-extended immediate.
- in_alu_control  in  4  ALU opcode.
- flush  in  1  kill contents (branch redirect).
- exmem_reg_write, exmem_rd_addr, exmem_result  in  1/REG_ADDR_WIDTH/DATA_WIDTH  EX/MEM forward source.
- memwb_reg_write, memwb_rd_addr, memwb_result  in  1/REG_ADDR_WIDTH/DATA_WIDTH  MEM/WB forward source.
- out_valid  out  1  ALU inputs valid.
- out_ready  in  1  execute consumes this cycle.
- out_rs1 / out_rs2  out  DATA_WIDTH  ALU operands.
- out_alu_control  out  4  ALU opcode.
- out_rd_addr  out  REG_ADDR_WIDTH; out_reg_write  out  1.
- out_illegal  out  1  opcode was not legal; sanitised.

Behaviour:
- Reset (rst_n=0 at edge): out_valid=0, out_rs1=out_rs2=0, out_alu_control=4'ha, out_rd_addr=0, out_reg_write=0, out_illegal=0, stored source addrs=0, use_imm flag=0.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - Load when in_valid && in_ready.
  - Latency is 1 cycle, input to out_valid.
  - Transfer out when out_valid && out_ready.
- States: EMPTY (out_valid=0) and FULL (out_valid=1).
  - EMPTY: stays EMPTY with no load; goes to FULL on load.
  - FULL with out_ready=1: reloads (FULL) if in_valid, otherwise goes to EMPTY.
  - FULL with out_ready=0: HOLD. Outputs stay stable except for the forwarding refresh below.
- Forwarding (per source, applied at capture):
  - EX/MEM match (reg_write=1, rd_addr==src, src!=0) wins over a MEM/WB match.
  - Otherwise the register-file data is used.
  - Source address 0 is never forwarded.
- Operand 2: when in_use_imm=1, in_imm is used and rs2 forwarding is suppressed.
- HOLD refresh:
  - Stored rs1/rs2 addresses are re-compared against EX/MEM and MEM/WB each held cycle, with the same priority rules.
  - A match overwrites the held operand, so no stale value is presented when the producer retires during a stall.
  - Immediate operands are never refreshed.
- Opcode sanitise:
  - Legal codes are 4'h0 through 4'hb.
  - Codes 4'hc through 4'hf load as out_alu_control=4'ha, out_reg_write=0, out_illegal=1.
- Flush:
  - Next cycle out_valid=0 and out_reg_write=0.
  - Flush has priority over a simultaneous load, and in_ready is ignored that cycle.
  - Flush during HOLD discards the held instruction.
- Reset mid-operation discards any held instruction. Nothing else is pending.
- No arithmetic is performed; widths pass through unchanged.

Optional Feature:
- Macro: ID_EX_FWD_COUNT_EN.
- Defined:
  - Adds outputs fwd_exmem_count and fwd_memwb_count, 16 bits each.
  - Each counts capture/refresh cycles in which that path supplied at least one operand.
  - Both saturate at 16'hffff and clear on reset.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset, then load rs1=5, rs2=7, ctrl=4'h0, out_ready=1 -> next cycle out_valid=1, out_rs1=5, out_rs2=7, out_alu_control=0; in_ready=1 throughout.
- Load with in_rs1_addr=3, exmem(we=1, rd=3, result=0x11) and memwb(we=1, rd=3, result=0x22) -> out_rs1=0x11. Repeat with src addr=0 and the same matches -> register-file data passes through.
- Fill, hold out_ready=0 for 3 cycles, memwb(rd=in_rs2_addr=4, result=0x99) in cycle 2 -> out_rs2 becomes 0x99 and stays; in_ready=0 throughout; the following instruction loads only after out_ready=1.
- Load ctrl=4'he, in_reg_write=1 -> out_alu_control=4'ha, out_reg_write=0, out_illegal=1.
- FULL with out_ready=0, assert flush together with in_valid -> next cycle out_valid=0; the new instruction is not captured.
- Drive rst_n=0 while FULL -> next cycle all outputs at reset values, out_alu_control=4'ha.
